// File: rtl/alu_pkg.sv
// Shared ALU operation codes and multiplier modes.
// Imported by the ALU and by the control decoder.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SLL   = 4'd1;
  localparam logic [3:0] ALU_SLT   = 4'd2;
  localparam logic [3:0] ALU_RSV3  = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SRL   = 4'd5;
  localparam logic [3:0] ALU_OR    = 4'd6;
  localparam logic [3:0] ALU_AND   = 4'd7;
  localparam logic [3:0] ALU_MUL   = 4'd8;
  localparam logic [3:0] ALU_MULH  = 4'd9;
  localparam logic [3:0] ALU_RSV10 = 4'd10;
  localparam logic [3:0] ALU_MULHU = 4'd11;
  localparam logic [3:0] ALU_SUB   = 4'd12;
  localparam logic [3:0] ALU_SRA   = 4'd13;
  localparam logic [3:0] ALU_SLTU  = 4'd14;
  localparam logic [3:0] ALU_BSEL  = 4'd15;

  typedef enum logic [1:0] {
    MUL_LO = 2'd0,
    MUL_HS = 2'd1,
    MUL_HU = 2'd2
  } mul_mode_e;

endpackage

// File: rtl/alu_mul.sv
// 32x32 multiplier returning the low half or a signed/unsigned
// high half of the 64-bit product.
module alu_mul
  import alu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  mul_mode_e   i_mode,
  output logic [31:0] o_res
);

  logic        w_sa;
  logic        w_sb;
  logic [63:0] w_ea;
  logic [63:0] w_eb;
  logic [63:0] w_p;

  // Low 64 bits of an unsigned multiply of the extended operands
  // equal the signed product when both are sign-extended.
  assign w_sa = (i_mode == MUL_HS) & i_a[31];
  assign w_sb = (i_mode == MUL_HS) & i_b[31];
  assign w_ea = {{32{w_sa}}, i_a};
  assign w_eb = {{32{w_sb}}, i_b};
  assign w_p  = w_ea * w_eb;

  always_comb begin
    o_res = 32'd0;
    case (i_mode)
      MUL_LO:  o_res = w_p[31:0];
      MUL_HS:  o_res = w_p[63:32];
      MUL_HU:  o_res = w_p[63:32];
      default: o_res = 32'd0;
    endcase
  end

endmodule

// File: rtl/rv_alu.sv
// RV32IM execute-stage ALU: combinational result plus
// a registered copy for the next pipeline stage.
module rv_alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  ALUSel,
  output logic [31:0] Out,
  output logic [31:0] OutReg
);

  logic [4:0]  w_sh;
  logic [31:0] w_sra;
  logic [31:0] w_mul;
  logic [31:0] w_out;
  mul_mode_e   w_mode;
  logic [31:0] r_out;

  assign w_sh  = B[4:0];
  assign w_sra = $signed(A) >>> w_sh;

  always_comb begin
    w_mode = MUL_LO;
    if (ALUSel == ALU_MULH)  w_mode = MUL_HS;
    if (ALUSel == ALU_MULHU) w_mode = MUL_HU;
  end

  alu_mul u_mul (
    .i_a    (A),
    .i_b    (B),
    .i_mode (w_mode),
    .o_res  (w_mul)
  );

  always_comb begin
    w_out = 32'd0;
    case (ALUSel)
      ALU_ADD:   w_out = A + B;
      ALU_SLL:   w_out = A << w_sh;
      ALU_SLT:   w_out = {31'd0, $signed(A) < $signed(B)};
      ALU_XOR:   w_out = A ^ B;
      ALU_SRL:   w_out = A >> w_sh;
      ALU_OR:    w_out = A | B;
      ALU_AND:   w_out = A & B;
      ALU_MUL:   w_out = w_mul;
      ALU_MULH:  w_out = w_mul;
      ALU_MULHU: w_out = w_mul;
      ALU_SUB:   w_out = A - B;
      ALU_SRA:   w_out = w_sra;
      ALU_SLTU:  w_out = {31'd0, A < B};
      ALU_BSEL:  w_out = B;
      default:   w_out = 32'd0;
    endcase
  end

  assign Out = w_out;

  always_ff @(posedge clk) begin
    if (rst) r_out <= 32'd0;
    else     r_out <= w_out;
  end

  assign OutReg = r_out;

endmodule

// File: tb/tb_rv_alu.sv
// Self-checking bench for rv_alu against a
// behavioural 64-bit arithmetic model.
module tb_rv_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [3:0]  ALUSel = 4'd0;
  logic [31:0] Out;
  logic [31:0] OutReg;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;
  logic [31:0] exp_reg = 32'd0;

  rv_alu dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .ALUSel (ALUSel),
    .Out    (Out),
    .OutReg (OutReg)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint          sa;
    longint          sb;
    longint          sp;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned up;
    int              sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    sh = int'(b % 32);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a << sh;
      4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd4:  return a ^ b;
      4'd5:  return a >> sh;
      4'd6:  return a | b;
      4'd7:  return a & b;
      4'd8:  begin up = ua * ub; return up[31:0]; end
      4'd9:  begin sp = sa * sb; return sp[63:32]; end
      4'd11: begin up = ua * ub; return up[63:32]; end
      4'd12: return a - b;
      4'd13: begin sp = sa >>> sh; return sp[31:0]; end
      4'd14: return (ua < ub) ? 32'd1 : 32'd0;
      4'd15: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(
    input string nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Every negedge: Out against the model, OutReg against last edge
  always @(posedge clk)
    exp_reg <= rst ? 32'd0 : model(ALUSel, A, B);

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_model", Out, model(ALUSel, A, B));
      check("outreg_model", OutReg, exp_reg);
    end
  end

  task automatic apply(
    input string nm,
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] lit
  );
    @(posedge clk);
    #1;
    ALUSel = op;
    A = a;
    B = b;
    #1;
    check(nm, Out, lit);
    check({nm, "_ref"}, model(op, a, b), lit);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [5];
    sp[0] = 32'h0;
    sp[1] = 32'h1;
    sp[2] = 32'hFFFFFFFF;
    sp[3] = 32'h80000000;
    sp[4] = 32'h7FFFFFFF;
    if ($urandom_range(0, 3) == 0)
      return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outreg", OutReg, 32'd0);

    @(posedge clk);
    #1;
    rst = 1'b0;
    ALUSel = 4'd0;
    A = 32'd5;
    B = 32'd7;
    #1;
    check("add_5_7_out", Out, 32'd12);
    @(posedge clk);
    #1;
    check("add_5_7_reg", OutReg, 32'd12);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_again_reg", OutReg, 32'd0);
    check("rst_again_out", Out, 32'd12);
    rst = 1'b0;
    chk_en = 1'b1;

    for (int a = 0; a < 10; a++)
      for (int b = 22; b < 32; b++)
        apply("add_sweep", 4'd0, a, b, 32'(a + b));

    apply("add_wrap", 4'd0, 32'hFFFFFFFF, 32'd1, 32'd0);
    apply("sub_wrap", 4'd12, 32'd0, 32'd1, 32'hFFFFFFFF);
    apply("slt_neg", 4'd2, 32'hFFFFFFFF, 32'd1, 32'd1);
    apply("sltu_big", 4'd14, 32'hFFFFFFFF, 32'd1, 32'd0);
    apply("sll_1", 4'd1, 32'h80000000, 32'h21, 32'd0);
    apply("srl_1", 4'd5, 32'h80000000, 32'h21, 32'h40000000);
    apply("sra_1", 4'd13, 32'h80000000, 32'h21, 32'hC0000000);
    apply("mul", 4'd8, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);
    apply("mulh", 4'd9, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
    apply("mulhu", 4'd11, 32'hFFFFFFFF, 32'd2, 32'h1);
    apply("xor", 4'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
    apply("or", 4'd6, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0);
    apply("and", 4'd7, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
    apply("bsel", 4'd15, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFF00FF00);
    apply("rsv3", 4'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0);
    apply("rsv10", 4'd10, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      ALUSel = 4'($urandom_range(0, 15));
      A = pick();
      B = pick();
      rst = ($urandom_range(0, 19) == 0);
    end

    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
